// File: rtl/vector_store_unit_pkg.sv
// Shared constants and state type for the vector store path.
// Imported by the interface and the vector_store_unit module.
package vector_pkg;
  localparam int VEC_W     = 128;
  localparam int WORD_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int BEATS     = VEC_W / WORD_W;
  localparam int BEAT_W    = $clog2(BEATS);
  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    VS_IDLE,
    VS_CAPTURE,
    VS_WRITE,
    VS_DONE
  } vs_state_t;
endpackage

// File: rtl/vector_store_unit_if.sv
// Data-memory write bus used by the vector store unit.
// The master drives one beat at a time; the slave accepts it with mem_ready.
interface vector_store_unit_if;
  import vector_pkg::*;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_ready;

  modport master (
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ready
  );

  modport slave (
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready
  );
endinterface

// File: rtl/vector_store_unit.sv
// Snapshots one vector register and writes it to memory as BEATS word beats,
// lowest word first, with a per-beat ready handshake.
module vector_store_unit
  import vector_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [REG_IDX_W-1:0] vs_reg,
  input  logic [ADDR_W-1:0]    base_addr,
  output logic [REG_IDX_W-1:0] rf_rs,
  input  logic [VEC_W-1:0]     rf_data,
  vector_store_unit_if.master  mem,
  output logic                 busy,
  output logic                 done
);

  vs_state_t            r_state;
  vs_state_t            w_next;
  logic [REG_IDX_W-1:0] r_idx;
  logic [ADDR_W-1:0]    r_base;
  logic [VEC_W-1:0]     r_buf;
  logic [BEAT_W-1:0]    r_beat;
  logic                 w_accept;

  assign w_accept = (r_state == VS_WRITE) && mem.mem_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= VS_IDLE;
      r_idx   <= '0;
      r_base  <= '0;
      r_buf   <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        VS_IDLE: begin
          if (start) begin
            r_idx  <= vs_reg;
            r_base <= {base_addr[ADDR_W-1:2], 2'b00};
          end
        end
        VS_CAPTURE: begin
          r_buf  <= rf_data;
          r_beat <= '0;
        end
        VS_WRITE: begin
          if (w_accept) r_beat <= r_beat + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      VS_IDLE:    if (start) w_next = VS_CAPTURE;
      VS_CAPTURE: w_next = VS_WRITE;
      VS_WRITE:   if (w_accept && (r_beat == BEAT_W'(BEATS - 1))) w_next = VS_DONE;
      VS_DONE:    w_next = VS_IDLE;
      default:    w_next = VS_IDLE;
    endcase
  end

  // Bus outputs are forced to zero outside WRITE so idle cycles carry no stale beat.
  always_comb begin
    rf_rs         = '0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    busy          = (r_state != VS_IDLE);
    done          = (r_state == VS_DONE);
    if (r_state == VS_CAPTURE) rf_rs = r_idx;
    if (r_state == VS_WRITE) begin
      mem.mem_we    = 1'b1;
      mem.mem_addr  = r_base + ADDR_W'({r_beat, 2'b00});
      mem.mem_wdata = r_buf[r_beat*WORD_W +: WORD_W];
    end
  end

endmodule

// File: tb/tb_vector_store_unit.sv
// Bench for vector_store_unit: directed table, random transfers against a
// word-list model of the store, and reset-abort sequence.
module tb_vector_store_unit;
  import vector_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [REG_IDX_W-1:0] vs_reg;
  logic [ADDR_W-1:0]    base_addr;
  logic [REG_IDX_W-1:0] rf_rs;
  logic [VEC_W-1:0]     rf_data;
  logic                 busy;
  logic                 done;

  logic                 rf_we;
  logic [4:0]           rf_wa;
  logic [127:0]         rf_wd;
  logic [127:0]         regs [32];

  int unsigned n_checks;
  int unsigned n_fail;

  vector_store_unit_if mif ();

  vector_store_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .vs_reg    (vs_reg),
    .base_addr (base_addr),
    .rf_rs     (rf_rs),
    .rf_data   (rf_data),
    .mem       (mif.master),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (rf_we) regs[rf_wa] <= rf_wd;
  assign rf_data = regs[rf_rs];

  typedef struct packed {
    logic [4:0]       idx;
    logic [127:0]     val;
    logic [31:0]      base;
    logic [3:0][1:0]  stall;
    logic             jwrite;
    logic             jdone;
    logic             rfw;
    logic [3:0][31:0] exp_addr;
    logic [3:0][31:0] exp_data;
    logic [7:0]       exp_done;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_reg(input logic [4:0] idx, input logic [127:0] val);
    rf_we = 1'b1; rf_wa = idx; rf_wd = val;
    @(posedge clk); @(negedge clk);
    rf_we = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic run_xfer(input vec_t v);
    int unsigned c, b, left;
    bit done_seen, acc;
    c = 1; b = 0; done_seen = 0;
    left = v.stall[0];
    start = 1'b1; vs_reg = v.idx; base_addr = v.base;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    while (!done_seen && c < 60) begin
      acc = 0;
      if (c == 1) begin
        chk("capture_rf_rs", rf_rs, v.idx);
        chk("capture_busy", busy, 1);
        chk("capture_we", mif.mem_we, 0);
      end
      rf_we = v.rfw && (c == 1 || c == 3);
      rf_wa = v.idx; rf_wd = '1;
      if (mif.mem_we) begin
        if (b < 4) begin
          chk("beat_addr", mif.mem_addr, v.exp_addr[b]);
          chk("beat_data", mif.mem_wdata, v.exp_data[b]);
        end else chk("extra_beat", b, 3);
        if (left > 0) begin
          mif.mem_ready = 1'b0; left--;
        end else begin
          mif.mem_ready = 1'b1; acc = 1;
        end
      end else mif.mem_ready = 1'($urandom_range(0, 1));
      if (done) begin
        done_seen = 1;
        chk("done_cycle", c, v.exp_done);
        chk("done_beats", b, 4);
        chk("done_bus_zero", {mif.mem_we, mif.mem_addr, mif.mem_wdata}, 0);
      end
      start  = (v.jwrite && c == 3) || (v.jdone && done);
      vs_reg = start ? 5'd5 : v.idx;
      @(posedge clk);
      if (acc) begin
        b++;
        if (b < 4) left = v.stall[b];
      end
      @(negedge clk);
      c++;
    end
    start = 1'b0; rf_we = 1'b0;
    if (!done_seen) chk("done_timeout", c, v.exp_done);
    chk("post_busy", busy, 0);
    chk("post_outputs", {mif.mem_we, rf_rs, done}, 0);
    @(posedge clk); @(negedge clk);
    chk("post_busy2", busy, 0);
  endtask

  function automatic vec_t mk(input logic [4:0] idx, input logic [127:0] val,
                              input logic [31:0] base, input logic [3:0][1:0] stall,
                              input logic jw, input logic jd, input logic rfw,
                              input logic [3:0][31:0] ea, input logic [3:0][31:0] ed,
                              input logic [7:0] edone);
    vec_t v;
    v.idx = idx; v.val = val; v.base = base; v.stall = stall;
    v.jwrite = jw; v.jdone = jd; v.rfw = rfw;
    v.exp_addr = ea; v.exp_data = ed; v.exp_done = edone;
    return v;
  endfunction

  localparam logic [127:0] R3 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] D3 = 128'h44444444_33333333_22222222_11111111;

  vec_t tbl [6];
  vec_t rv;
  bit   bad;
  int unsigned tot;

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; vs_reg = '0; base_addr = '0;
    mif.mem_ready = 1'b1; rf_we = 1'b0; rf_wa = '0; rf_wd = '0;

    tbl[0] = mk(5'd3, R3, 32'h100, 8'h00, 0, 0, 0,
                {32'h10C, 32'h108, 32'h104, 32'h100}, D3, 8'd6);
    tbl[1] = mk(5'd3, R3, 32'h100, {2'd0, 2'd0, 2'd3, 2'd0}, 0, 0, 0,
                {32'h10C, 32'h108, 32'h104, 32'h100}, D3, 8'd9);
    tbl[2] = mk(5'd3, R3, 32'h100, 8'h00, 1, 1, 0,
                {32'h10C, 32'h108, 32'h104, 32'h100}, D3, 8'd6);
    tbl[3] = mk(5'd3, R3, 32'h100, 8'h00, 0, 0, 1,
                {32'h10C, 32'h108, 32'h104, 32'h100}, D3, 8'd6);
    tbl[4] = mk(5'd9, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 32'hFFFF_FFFB, 8'h00, 0, 0, 0,
                {32'h4, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFF8},
                128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 8'd6);
    tbl[5] = mk(5'd31, 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0, 32'hFFFF_FFF8, {2'd1, 2'd0, 2'd2, 2'd1}, 0, 0, 0,
                {32'h4, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFF8},
                128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0, 8'd10);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {busy, done, rf_rs, mif.mem_we, mif.mem_addr, mif.mem_wdata}, 0);
    rst_n = 1'b1;
    set_reg(5'd5, 128'h55555555_55555555_55555555_55555555);

    for (int i = 0; i < 6; i++) begin
      set_reg(tbl[i].idx, tbl[i].val);
      run_xfer(tbl[i]);
    end

    // Model: beat i carries word i of the register value at start, address base&~3 + 4i.
    for (int n = 0; n < 16; n++) begin
      rv.idx  = 5'($urandom_range(0, 31));
      rv.val  = {$urandom, $urandom, $urandom, $urandom};
      rv.base = $urandom;
      tot = 0;
      for (int k = 0; k < 4; k++) begin
        rv.stall[k] = 2'($urandom_range(0, 2));
        tot += rv.stall[k];
      end
      rv.jwrite = 1'($urandom_range(0, 1));
      rv.jdone  = 1'($urandom_range(0, 1));
      rv.rfw    = 1'($urandom_range(0, 1));
      for (int k = 0; k < 4; k++) begin
        rv.exp_addr[k] = (rv.base & 32'hFFFF_FFFC) + 32'(4 * k);
        rv.exp_data[k] = 32'((rv.val >> (32 * k)) & 128'hFFFF_FFFF);
      end
      rv.exp_done = 8'(6 + tot);
      set_reg(rv.idx, rv.val);
      run_xfer(rv);
    end

    // Reset right after beat 1 is accepted aborts the transfer.
    set_reg(5'd7, 128'h87654321_FEDCBA98_76543210_0BADF00D);
    mif.mem_ready = 1'b1;
    start = 1'b1; vs_reg = 5'd7; base_addr = 32'h200;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_seq_beat0", {mif.mem_addr, mif.mem_wdata}, {32'h200, 32'h0BADF00D});
    @(posedge clk); @(negedge clk);
    chk("rst_seq_beat1", {mif.mem_addr, mif.mem_wdata}, {32'h204, 32'h76543210});
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    chk("abort_outputs", {busy, done, rf_rs, mif.mem_we, mif.mem_addr, mif.mem_wdata}, 0);
    bad = 0;
    repeat (8) begin
      @(posedge clk); @(negedge clk);
      if (mif.mem_we || done || busy) bad = 1;
    end
    chk("abort_quiet", bad, 0);
    run_xfer(mk(5'd7, 128'h87654321_FEDCBA98_76543210_0BADF00D, 32'h200, 8'h00, 0, 0, 0,
                {32'h20C, 32'h208, 32'h204, 32'h200},
                128'h87654321_FEDCBA98_76543210_0BADF00D, 8'd6));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
